// File: rtl/opb_master_bridge.sv
// rtl/opb_master_bridge.sv - single-outstanding OPB master turning valid/ready commands into OPB transfers
// Optional build macro OPB_MASTER_RETRY_EN: reissue after OPB_retry with backoff, up to MAX_RETRIES times.
module opb_master_bridge #(
    parameter int C_OPB_AWIDTH   = 32,
    parameter int C_OPB_DWIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRIES    = 3,
    parameter int RETRY_BACKOFF  = 4
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_rnw,
    input  logic [C_OPB_AWIDTH-1:0]   req_addr,
    input  logic [C_OPB_DWIDTH-1:0]   req_wdata,
    input  logic [C_OPB_DWIDTH/8-1:0] req_be,
    output logic                      rsp_valid,
    output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
    output logic [1:0]                rsp_status,
    output logic                      M_request,
    input  logic                      OPB_MGrant,
    output logic                      M_select,
    output logic                      M_RNW,
    output logic                      M_seqAddr,
    output logic [C_OPB_DWIDTH/8-1:0] M_BE,
    output logic [C_OPB_AWIDTH-1:0]   M_ABus,
    output logic [C_OPB_DWIDTH-1:0]   M_DBus,
    input  logic [C_OPB_DWIDTH-1:0]   OPB_DBus,
    input  logic                      OPB_xferAck,
    input  logic                      OPB_errAck,
    input  logic                      OPB_retry,
    input  logic                      OPB_toutSup
);
    localparam int BW = C_OPB_DWIDTH / 8;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TOUT  = 2'b10;
    localparam logic [1:0] ST_RETRY = 2'b11;

    typedef enum logic [2:0] {IDLE, REQ, XFER, BACKOFF, RESP} state_t;

    state_t                  state_q;
    logic [TW-1:0]           tout_q;
    logic                    cmd_rnw_q;
    logic [C_OPB_AWIDTH-1:0] cmd_addr_q;
    logic [C_OPB_DWIDTH-1:0] cmd_wdata_q;
    logic [BW-1:0]           cmd_be_q;

    logic                    req_ready_q, rsp_valid_q, m_request_q, m_select_q, m_rnw_q;
    logic [C_OPB_DWIDTH-1:0] rsp_rdata_q, m_dbus_q;
    logic [1:0]              rsp_status_q;
    logic [BW-1:0]           m_be_q;
    logic [C_OPB_AWIDTH-1:0] m_abus_q;

    logic                    xfer_done, go_backoff;
    logic [1:0]              xfer_status;
    logic [C_OPB_DWIDTH-1:0] xfer_rdata;

`ifdef OPB_MASTER_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    localparam int OW = $clog2(RETRY_BACKOFF + 1);
    logic [RW-1:0] retry_cnt_q;
    logic [OW-1:0] backoff_q;
`else
    logic unused_retry_cfg;
    assign unused_retry_cfg = ^{MAX_RETRIES, RETRY_BACKOFF};
`endif

    // Outcome of the current XFER cycle; only consulted while in XFER, where M_select is high.
    always_comb begin
        xfer_done   = 1'b0;
        go_backoff  = 1'b0;
        xfer_status = ST_OK;
        xfer_rdata  = '0;
        if (OPB_xferAck) begin
            xfer_done = 1'b1;
            if (OPB_errAck)
                xfer_status = ST_ERR;
            else if (cmd_rnw_q)
                xfer_rdata = OPB_DBus;
        end else if (OPB_retry) begin
`ifdef OPB_MASTER_RETRY_EN
            if (retry_cnt_q == RW'(MAX_RETRIES)) begin
                xfer_done   = 1'b1;
                xfer_status = ST_RETRY;
            end else begin
                go_backoff = 1'b1;
            end
`else
            xfer_done   = 1'b1;
            xfer_status = ST_RETRY;
`endif
        end else if (!OPB_toutSup && tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            xfer_done   = 1'b1;
            xfer_status = ST_TOUT;
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q      <= IDLE;
            tout_q       <= '0;
            cmd_rnw_q    <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            cmd_be_q     <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_status_q <= ST_OK;
            m_request_q  <= 1'b0;
            m_select_q   <= 1'b0;
            m_rnw_q      <= 1'b0;
            m_be_q       <= '0;
            m_abus_q     <= '0;
            m_dbus_q     <= '0;
`ifdef OPB_MASTER_RETRY_EN
            retry_cnt_q  <= '0;
            backoff_q    <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        cmd_rnw_q   <= req_rnw;
                        cmd_addr_q  <= req_addr;
                        cmd_wdata_q <= req_wdata;
                        cmd_be_q    <= req_be;
                        req_ready_q <= 1'b0;
                        m_request_q <= 1'b1;
                        state_q     <= REQ;
`ifdef OPB_MASTER_RETRY_EN
                        retry_cnt_q <= '0;
`endif
                    end
                end
                REQ: begin
                    m_request_q <= 1'b1;
                    if (OPB_MGrant) begin
                        m_select_q <= 1'b1;
                        m_rnw_q    <= cmd_rnw_q;
                        m_abus_q   <= cmd_addr_q;
                        m_be_q     <= cmd_be_q;
                        m_dbus_q   <= cmd_rnw_q ? '0 : cmd_wdata_q;
                        tout_q     <= '0;
                        state_q    <= XFER;
                    end
                end
                XFER: begin
                    if (xfer_done || go_backoff) begin
                        // Bus fields return to zero together with M_select for the OR-bus.
                        m_request_q <= 1'b0;
                        m_select_q  <= 1'b0;
                        m_rnw_q     <= 1'b0;
                        m_abus_q    <= '0;
                        m_be_q      <= '0;
                        m_dbus_q    <= '0;
                        if (xfer_done) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_rdata_q  <= xfer_rdata;
                            rsp_status_q <= xfer_status;
                            state_q      <= RESP;
                        end
`ifdef OPB_MASTER_RETRY_EN
                        else begin
                            backoff_q <= '0;
                            state_q   <= BACKOFF;
                        end
`endif
                    end else if (!OPB_toutSup) begin
                        tout_q <= tout_q + 1'b1;
                    end
                end
`ifdef OPB_MASTER_RETRY_EN
                BACKOFF: begin
                    if (backoff_q == OW'(RETRY_BACKOFF - 1)) begin
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                        m_request_q <= 1'b1;
                        state_q     <= REQ;
                    end else begin
                        backoff_q <= backoff_q + 1'b1;
                    end
                end
`endif
                RESP: begin
                    rsp_rdata_q  <= '0;
                    rsp_status_q <= ST_OK;
                    req_ready_q  <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_status = rsp_status_q;
    assign M_request  = m_request_q;
    assign M_select   = m_select_q;
    assign M_RNW      = m_rnw_q;
    assign M_seqAddr  = 1'b0;
    assign M_BE       = m_be_q;
    assign M_ABus     = m_abus_q;
    assign M_DBus     = m_dbus_q;
endmodule
